bus_mailbox: RTL and testbench
==============================

# bus_mailbox

Memory-mapped bus responder giving the core a bidirectional word mailbox to an external streaming agent. It sits as one device on the simple-system bus, behind a 1 kB window, alongside RAM, simulator control and timer. Bus writes push into a TX FIFO that drains through a valid/ready stream output. A valid/ready stream input fills an RX FIFO that the bus pops by reading. A level interrupt reports FIFO conditions.

## Interface
- Depth, 8: entries per FIFO; power of two, 2..128.
- DataWidth, 32: bus and stream data width.
- AddressWidth, 32: bus address width.

- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- dev_req_i  input  1  bus request; granted by the bus in the same cycle
- dev_we_i  input  1  1 = write, 0 = read
- dev_be_i  input  4  byte enables
- dev_addr_i  input  AddressWidth  byte address; full address as routed by the bus
- dev_wdata_i  input  DataWidth  write data
- dev_rvalid_o  output  1  response strobe
- dev_rdata_o  output  DataWidth  read data, qualified by dev_rvalid_o
- dev_err_o  output  1  error response, qualified by dev_rvalid_o
- tx_valid_o  output  1  TX stream has data
- tx_ready_i  input  1  TX consumer accepts
- tx_data_o  output  DataWidth  TX head word
- rx_valid_i  input  1  RX producer offers data
- rx_ready_o  output  1  RX FIFO can accept
- rx_data_i  input  DataWidth  RX word
- irq_o  output  1  level interrupt

## Operation
- Decode uses offset dev_addr_i[9:0]. Any access with dev_addr_i[9:4] != 0 returns an error with no side effect.
- Register map:
  - 0x0 TXDATA, write-only. A write pushes dev_wdata_i. A read returns 0 with no error.
  - 0x4 RXDATA, read-only. A read pops and returns the head word. A write returns an error.
  - 0x8 STATUS, read-only. [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [15:8] tx_count, [23:16] rx_count. Counts are zero-extended. A write returns an error.
  - 0xC CTRL, read/write.
    - [0] rx_irq_en and [1] tx_irq_en are stored bits.
    - [8] tx_flush and [9] rx_flush are write-1 pulses that always read as 0.
    - Writes honour dev_be_i[0] for [1:0] and dev_be_i[1] for [9:8].
- A write to TXDATA requires dev_be_i == 4'hF; otherwise the write returns an error and nothing is pushed.
- Errors:
  - A TXDATA write while tx_full returns an error and the word is dropped.
  - An RXDATA read while rx_empty returns an error and rdata = 0.
- On an error response, rdata = 0.
- FIFOs are circular buffers with Depth entries. Read and write pointers are log2(Depth) bits and wrap naturally. Counts are log2(Depth)+1 bits.
- Full and empty are evaluated on the registered count at the start of the cycle. A TXDATA write to a full FIFO is rejected even if tx_ready_i pops in the same cycle.
- TX stream:
  - tx_valid_o = !tx_empty and tx_data_o = TX head, both from registered state.
  - A pop occurs when tx_valid_o and tx_ready_i are both high.
  - If a pop and a push happen in the same cycle, the count is unchanged.
- RX stream:
  - rx_ready_o = !rx_full && !rst_i.
  - A push occurs when rx_valid_i and rx_ready_o are both high.
  - A same-cycle bus pop and stream push are both performed.
- Flush sets the FIFO's pointers and count to 0 at the clock edge.
  - A same-cycle TX stream handshake still completes; the word was delivered.
  - A same-cycle RX push is discarded.
  - A same-cycle bus push or pop on the flushed FIFO is discarded, and the response is as if the FIFO were empty.
- irq_o is registered: irq_o <= (rx_irq_en & !rx_empty_next) | (tx_irq_en & tx_empty_next).

## Timing
- Every dev_req_i produces exactly one dev_rvalid_o pulse in the next cycle, for both reads and writes. There is no backpressure, so back-to-back requests give back-to-back responses.
- dev_rdata_o and dev_err_o are registered and valid only while dev_rvalid_o is high; otherwise they hold 0.
- State effects take place at the request edge:
  - A pushed TX word is visible on tx_valid_o in the next cycle.
  - An RX word pushed at edge N is readable by a request issued in cycle N+1.
  - STATUS reflects state before the request edge.
- irq_o reflects FIFO state one cycle after the change.
- Reset, asynchronous and active-high; while rst_i is high:
  - dev_rvalid_o = 0, dev_rdata_o = 0, dev_err_o = 0, tx_valid_o = 0, rx_ready_o = 0, irq_o = 0, CTRL = 0.
  - Both FIFOs are empty.
  - Assertion mid-transaction drops any pending response. There is no rvalid after reset deassertion for a request issued before reset.
- rx_ready_o rises combinationally on deassertion of rst_i.
- tx_data_o is undefined while tx_valid_o is low; the bench must not check it then.

## Test plan
- Reset, then write 0xDEADBEEF and 0x12345678 to 0x0 with tx_ready_i = 0.
  - Each gets an rvalid one cycle later with err = 0.
  - STATUS reads 0x0000_0208.
  - Raising tx_ready_i streams both words out in order, after which tx_valid_o = 0.
- Fill TX with Depth words while tx_ready_i = 0, then issue one more write.
  - The extra write returns err = 1.
  - The drained sequence equals the first Depth words.
  - Repeat over 3 × Depth words with random ready to cover pointer wrap.
- Stream 0xA5A5_0001 … 0xA5A5_0009 into RX with Depth = 8.
  - rx_ready_o falls after 8 words.
  - Reads of 0x4 return the words in order.
  - The 9th read returns err = 1 and rdata = 0.
  - A same-cycle push and pop keeps rx_count unchanged.
- Accesses to illegal or misused addresses:
  - A read of 0x10 and a write of 0x4 return err = 1 with state unchanged.
  - A TXDATA write with be = 4'h3 returns err = 1 with no push.
  - A read of 0x0 returns 0 with err = 0.
- Interrupt:
  - Write CTRL = 0x1 and push one RX word: irq_o rises one cycle later and falls one cycle after the pop.
  - Write CTRL = 0x2 with TX empty: irq_o = 1.
  - Write CTRL = 0x302: both FIFOs are emptied and CTRL reads 0x2.
- Assert rst_i during a pending read and while TX holds 3 words.
  - No rvalid follows, and all outputs go to 0 asynchronously.
  - After release, STATUS reads 0x0000_000A.

Source files
------------

// File: rtl/bus_mailbox.sv
// Bus-mapped word mailbox: TXDATA writes feed a valid/ready TX stream, RX stream fills a FIFO popped by RXDATA reads.
// Latency: one cycle from dev_req_i to dev_rvalid_o; pushed TX words appear on tx_valid_o the cycle after the write.
// Backpressure: none on the bus (error on TX full / RX empty); RX stream is held off by rx_ready_o while the RX FIFO is full.
module bus_mailbox #(
  parameter int Depth        = 8,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [DataWidth-1:0]    tx_data_o,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [DataWidth-1:0]    rx_data_i,
  output logic                    irq_o
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

  // Storage and pointers
  logic [DataWidth-1:0] r_tx_mem [Depth];
  logic [DataWidth-1:0] r_rx_mem [Depth];
  logic [PW-1:0]        r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]        r_tx_cnt, r_rx_cnt;
  logic                 r_rx_irq_en, r_tx_irq_en;
  logic                 r_rvalid, r_err, r_irq;
  logic [DataWidth-1:0] r_rdata;

  // Decode
  logic                 w_bad;
  logic [1:0]           w_reg;
  logic                 w_unused_addr;
  logic                 w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic                 w_ctrl_wr, w_tx_flush, w_rx_flush;
  logic                 w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [CW-1:0]        w_tx_cnt_nxt, w_rx_cnt_nxt;
  logic                 w_rx_irq_en_nxt, w_tx_irq_en_nxt;
  logic [DataWidth-1:0] w_status;
  logic [DataWidth-1:0] w_rsp_dat;
  logic                 w_rsp_err;

  assign w_bad         = |dev_addr_i[9:4];
  assign w_reg         = dev_addr_i[3:2];
  assign w_unused_addr = ^{dev_addr_i[AddressWidth-1:10], dev_addr_i[1:0]};

  // Full/empty come from the count registered at the start of the cycle
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_ctrl_wr  = dev_req_i && dev_we_i && !w_bad && (w_reg == 2'd3);
  assign w_tx_flush = w_ctrl_wr && dev_be_i[1] && dev_wdata_i[8];
  assign w_rx_flush = w_ctrl_wr && dev_be_i[1] && dev_wdata_i[9];

  // A single request is either a CTRL flush or a data access, never both,
  // so bus push/pop never collide with a flush of the same FIFO.
  assign w_tx_push = dev_req_i && dev_we_i && !w_bad && (w_reg == 2'd0) &&
                     (dev_be_i == 4'hF) && !w_tx_full;
  assign w_tx_pop  = tx_valid_o && tx_ready_i;
  assign w_rx_push = rx_valid_i && rx_ready_o;
  assign w_rx_pop  = dev_req_i && !dev_we_i && !w_bad && (w_reg == 2'd1) && !w_rx_empty;

  assign w_tx_cnt_nxt = w_tx_flush ? '0 : r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
  assign w_rx_cnt_nxt = w_rx_flush ? '0 : r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);

  assign w_rx_irq_en_nxt = (w_ctrl_wr && dev_be_i[0]) ? dev_wdata_i[0] : r_rx_irq_en;
  assign w_tx_irq_en_nxt = (w_ctrl_wr && dev_be_i[0]) ? dev_wdata_i[1] : r_tx_irq_en;

  // Stream-side outputs
  assign tx_valid_o   = !w_tx_empty;
  assign tx_data_o    = r_tx_mem[r_tx_rptr];
  assign rx_ready_o   = !w_rx_full && !rst_i;
  assign dev_rvalid_o = r_rvalid;
  assign dev_rdata_o  = r_rdata;
  assign dev_err_o    = r_err;
  assign irq_o        = r_irq;

  // Assemble the STATUS word from pre-edge state
  always_comb begin
    w_status           = '0;
    w_status[0]        = w_tx_full;
    w_status[1]        = w_tx_empty;
    w_status[2]        = w_rx_full;
    w_status[3]        = w_rx_empty;
    w_status[8  +: CW] = r_tx_cnt;
    w_status[16 +: CW] = r_rx_cnt;
  end

  // Response data and error for the current request
  always_comb begin
    w_rsp_dat = '0;
    w_rsp_err = 1'b0;
    if (w_bad) begin
      w_rsp_err = 1'b1;
    end else begin
      case (w_reg)
        2'd0: if (dev_we_i) w_rsp_err = (dev_be_i != 4'hF) || w_tx_full;
        2'd1: begin
          if (dev_we_i || w_rx_empty) w_rsp_err = 1'b1;
          else                        w_rsp_dat = r_rx_mem[r_rx_rptr];
        end
        2'd2: begin
          if (dev_we_i) w_rsp_err = 1'b1;
          else          w_rsp_dat = w_status;
        end
        default: begin
          if (!dev_we_i) begin
            w_rsp_dat[0] = r_rx_irq_en;
            w_rsp_dat[1] = r_tx_irq_en;
          end
        end
      endcase
    end
  end

  // Bus response register; reset drops any pending response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= dev_req_i;
      r_rdata  <= dev_req_i ? w_rsp_dat : '0;
      r_err    <= dev_req_i && w_rsp_err;
    end
  end

  // TX FIFO pointers and count; flush wins over push/pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else if (w_tx_flush) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      r_tx_wptr <= r_tx_wptr + PW'(w_tx_push);
      r_tx_rptr <= r_tx_rptr + PW'(w_tx_pop);
      r_tx_cnt  <= w_tx_cnt_nxt;
    end
  end

  // RX FIFO pointers and count; flush discards a same-cycle stream push
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else if (w_rx_flush) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      r_rx_wptr <= r_rx_wptr + PW'(w_rx_push);
      r_rx_rptr <= r_rx_rptr + PW'(w_rx_pop);
      r_rx_cnt  <= w_rx_cnt_nxt;
    end
  end

  // FIFO storage writes; contents need no reset since pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= dev_wdata_i;
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data_i;
  end

  // CTRL enables and the level interrupt from post-edge FIFO state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_irq_en <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_rx_irq_en <= w_rx_irq_en_nxt;
      r_tx_irq_en <= w_tx_irq_en_nxt;
      r_irq       <= (w_rx_irq_en_nxt && (w_rx_cnt_nxt != '0)) ||
                     (w_tx_irq_en_nxt && (w_tx_cnt_nxt == '0));
    end
  end

endmodule

// File: tb/tb_bus_mailbox.sv
// Directed bench for bus_mailbox with Depth = 8: bus register map, TX/RX streaming, errors, interrupt and reset.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// A small queue model tracks the TX FIFO during the random-ready wrap phase.
module tb_bus_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        dev_req, dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_rvalid, dev_err;
  logic [31:0] dev_rdata;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_data;
  logic        irq;

  int tests = 0;
  int fails = 0;

  bus_mailbox #(.Depth(8), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .dev_req_i(dev_req), .dev_we_i(dev_we), .dev_be_i(dev_be),
    .dev_addr_i(dev_addr), .dev_wdata_i(dev_wdata),
    .dev_rvalid_o(dev_rvalid), .dev_rdata_o(dev_rdata), .dev_err_o(dev_err),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns the response captured one cycle later
  task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    dev_req = 1'b1; dev_we = we; dev_addr = addr; dev_be = be; dev_wdata = wd;
    @(posedge clk); #1;
    dev_req = 1'b0; dev_we = 1'b0; dev_be = 4'h0;
    chk("rvalid", {31'b0, dev_rvalid}, 32'd1);
    rd = dev_rdata;
    er = dev_err;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] be,
                    input logic [31:0] wd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    bus(1'b1, addr, be, wd, rd, er);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic rdc(input string tag, input logic [31:0] addr,
                     input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    bus(1'b0, addr, 4'hF, 32'h0, rd, er);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic [31:0] q[$];
  int          sent;
  int          ncyc;
  logic        pop_exp, full_exp, er;
  logic [31:0] rd;

  initial begin
    rst = 1'b0; dev_req = 1'b0; dev_we = 1'b0; dev_be = 4'h0;
    dev_addr = 32'h0; dev_wdata = 32'h0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = 32'h0;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // ---- reset state
    chk("rst_rvalid", {31'b0, dev_rvalid}, 32'd0);
    chk("rst_rdata", dev_rdata, 32'd0);
    chk("rst_err", {31'b0, dev_err}, 32'd0);
    chk("rst_txv", {31'b0, tx_valid}, 32'd0);
    chk("rst_rxr", {31'b0, rx_ready}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    cyc();
    rst = 1'b0;
    #1 chk("rel_rxr", {31'b0, rx_ready}, 32'd1);
    cyc();

    // ---- basic TX
    wr("tx0", 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    wr("tx1", 32'h0, 4'hF, 32'h12345678, 1'b0);
    rdc("stat2", 32'h8, 32'h0000_0208, 1'b0);
    chk("idle_rvalid", {31'b0, dev_rvalid}, 32'd1);
    cyc();
    chk("idle_rvalid0", {31'b0, dev_rvalid}, 32'd0);
    chk("idle_rdata0", dev_rdata, 32'd0);
    chk("txv_a", {31'b0, tx_valid}, 32'd1);
    chk("txd_a", tx_data, 32'hDEADBEEF);
    tx_ready = 1'b1;
    cyc();
    chk("txv_b", {31'b0, tx_valid}, 32'd1);
    chk("txd_b", tx_data, 32'h12345678);
    cyc();
    chk("txv_c", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // ---- fill TX, overflow, drain
    for (int i = 0; i < 8; i++) wr("fill", 32'h0, 4'hF, 32'h100 + i, 1'b0);
    wr("fill_over", 32'h0, 4'hF, 32'hBAD0_0000, 1'b1);
    rdc("stat_full", 32'h8, 32'h0000_0809, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_v", {31'b0, tx_valid}, 32'd1);
      chk("drain_d", tx_data, 32'h100 + i);
      cyc();
    end
    chk("drain_end", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // ---- pointer wrap with random ready, modelled by a queue
    sent = 0; ncyc = 0;
    while ((sent < 24 || q.size() != 0) && ncyc < 400) begin
      ncyc++;
      tx_ready = 1'($urandom_range(0, 1));
      chk("wrap_v", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      pop_exp = (q.size() != 0) && tx_ready;
      if (pop_exp) chk("wrap_d", tx_data, q[0]);
      if (sent < 24) begin
        full_exp = (q.size() == 8);
        bus(1'b1, 32'h0, 4'hF, 32'hC000_0000 + sent, rd, er);
        chk("wrap_err", {31'b0, er}, {31'b0, full_exp});
        if (!full_exp) begin
          q.push_back(32'hC000_0000 + sent);
          sent++;
        end
      end else begin
        cyc();
      end
      if (pop_exp) void'(q.pop_front());
    end
    chk("wrap_done", ncyc, ncyc < 400 ? ncyc : 0);
    tx_ready = 1'b0;

    // ---- RX fill to full
    for (int i = 1; i <= 9; i++) begin
      rx_valid = 1'b1;
      rx_data  = 32'hA5A5_0000 + i;
      chk("rx_rdy", {31'b0, rx_ready}, {31'b0, i < 9});
      cyc();
    end
    rx_valid = 1'b0;
    chk("rx_rdy_full", {31'b0, rx_ready}, 32'd0);
    rdc("stat_rxfull", 32'h8, 32'h0008_0006, 1'b0);
    rdc("rx1", 32'h4, 32'hA5A5_0001, 1'b0);
    rx_valid = 1'b1; rx_data = 32'hBEEF_0000;
    rdc("rx2", 32'h4, 32'hA5A5_0002, 1'b0);
    rx_valid = 1'b0;
    rdc("stat_rx7", 32'h8, 32'h0007_0002, 1'b0);
    for (int i = 3; i <= 8; i++) rdc("rxn", 32'h4, 32'hA5A5_0000 + i, 1'b0);
    rdc("rx_last", 32'h4, 32'hBEEF_0000, 1'b0);
    rdc("rx_empty", 32'h4, 32'h0, 1'b1);

    // ---- illegal / misused accesses
    rdc("bad_addr", 32'h10, 32'h0, 1'b1);
    rdc("bad_hi", 32'h3F0, 32'h0, 1'b1);
    wr("wr_rx", 32'h4, 4'hF, 32'h1, 1'b1);
    wr("wr_stat", 32'h8, 4'hF, 32'h1, 1'b1);
    rdc("stat_same", 32'h8, 32'h0000_000A, 1'b0);
    wr("tx_be3", 32'h0, 4'h3, 32'h5555_5555, 1'b1);
    chk("tx_be3_v", {31'b0, tx_valid}, 32'd0);
    rdc("stat_be3", 32'h8, 32'h0000_000A, 1'b0);
    rdc("rd_tx", 32'h0, 32'h0, 1'b0);

    // ---- interrupt
    wr("ctrl1", 32'hC, 4'hF, 32'h1, 1'b0);
    chk("irq_a", {31'b0, irq}, 32'd0);
    rx_valid = 1'b1; rx_data = 32'h7777_0001;
    cyc();
    rx_valid = 1'b0;
    chk("irq_rx", {31'b0, irq}, 32'd1);
    rdc("irq_pop", 32'h4, 32'h7777_0001, 1'b0);
    chk("irq_fall", {31'b0, irq}, 32'd0);
    wr("ctrl2", 32'hC, 4'hF, 32'h2, 1'b0);
    chk("irq_tx", {31'b0, irq}, 32'd1);
    rdc("ctrl_rd", 32'hC, 32'h2, 1'b0);
    wr("txi", 32'h0, 4'hF, 32'h1111_1111, 1'b0);
    chk("irq_txne", {31'b0, irq}, 32'd0);
    wr("txj", 32'h0, 4'hF, 32'h2222_2222, 1'b0);
    rx_valid = 1'b1; rx_data = 32'h3333_3333;
    cyc();
    rx_valid = 1'b0;
    rdc("stat_pre", 32'h8, 32'h0001_0200, 1'b0);
    wr("flush", 32'hC, 4'hF, 32'h302, 1'b0);
    rdc("stat_flush", 32'h8, 32'h0000_000A, 1'b0);
    rdc("ctrl_flush", 32'hC, 32'h2, 1'b0);
    chk("irq_flush", {31'b0, irq}, 32'd1);

    // ---- reset during a pending read with TX holding 3 words
    wr("ctrl_rx", 32'hC, 4'hF, 32'h1, 1'b0);
    rx_valid = 1'b1; rx_data = 32'h4444_4444;
    cyc();
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) wr("tx3", 32'h0, 4'hF, 32'h900 + i, 1'b0);
    chk("pre_irq", {31'b0, irq}, 32'd1);
    chk("pre_txv", {31'b0, tx_valid}, 32'd1);
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h8; dev_be = 4'hF;
    cyc();
    chk("pre_rvalid", {31'b0, dev_rvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    dev_req = 1'b0;
    chk("ar_rvalid", {31'b0, dev_rvalid}, 32'd0);
    chk("ar_rdata", dev_rdata, 32'd0);
    chk("ar_err", {31'b0, dev_err}, 32'd0);
    chk("ar_txv", {31'b0, tx_valid}, 32'd0);
    chk("ar_rxr", {31'b0, rx_ready}, 32'd0);
    chk("ar_irq", {31'b0, irq}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("rel2_rxr", {31'b0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rel2_rvalid", {31'b0, dev_rvalid}, 32'd0);
    rdc("stat_rst", 32'h8, 32'h0000_000A, 1'b0);
    rdc("ctrl_rst", 32'hC, 32'h0, 1'b0);
    chk("irq_rst", {31'b0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
